// File: rtl/seg_pkg.sv
// Shared types for the segment scan controller: digit encodings, conversion states, scan index.
// Pure definitions; no logic, no latency, no flow control.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    typedef logic [1:0] scan_idx_t;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] scan_an(input scan_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Requester strobes, busy status and board display pins of the segment scan controller.
// Strobes are fire-and-forget; busy is status only, never a stall.
interface seg_scan_ctrl_if #(
    parameter int VAL_W = 8
);
    logic [VAL_W-1:0] score;
    logic             score_vld;
    logic [VAL_W-1:0] time_s;
    logic             time_vld;
    logic             busy;
    logic [6:0]       seg;
    logic [3:0]       an;
    logic             dp;

    modport master (
        output score, score_vld, time_s, time_vld,
        input  busy, seg, an, dp
    );

    modport slave (
        input  score, score_vld, time_s, time_vld,
        output busy, seg, an, dp
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble of a 0..99 value: start -> LOAD -> 8x SHIFT -> DONE (done high one cycle).
// No backpressure; start is only honoured in IDLE.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state;
    logic [15:0] sr;
    logic [2:0]  cnt;
    logic [15:0] adj;

    always_comb begin
        adj = sr;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    sr    <= {8'h00, 1'b0, bin};
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr  <= adj << 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done = (state == ST_DONE);
    assign tens = sr[15:12];
    assign ones = sr[11:8];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin shares one BCD converter between score/time requesters and scans 4 digits (11-edge update latency).
// Strobes never stall; SEG_LEADING_ZERO_BLANK_EN blanks zero tens digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter int VAL_W       = 8
)(
    input  logic segclk,
    input  logic reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic             pend_score, pend_time;
    logic [VAL_W-1:0] pval_score, pval_time;
    logic             prio_time;
    logic             conv_act, load_ph, grant_time;
    logic             start, gsel_time;
    logic [VAL_W-1:0] sel_val;
    logic [6:0]       bin;
    logic             conv_done;
    logic [3:0]       conv_tens, conv_ones;
    logic [3:0]       score_tens, score_ones, time_tens, time_ones;

    scan_idx_t        idx;
    logic [DW-1:0]    dwell;
    logic [3:0]       cur_digit;
    logic [6:0]       nxt_seg, seg_q;
    logic [3:0]       nxt_an, an_q;
    logic             nxt_dp, dp_q;

    // Arbitration only while the converter is idle; priority flips only on contention.
    assign start     = !conv_act && (pend_score || pend_time);
    assign gsel_time = pend_time && (!pend_score || prio_time);

    always_ff @(posedge segclk) begin
        if (reset) begin
            conv_act   <= 1'b0;
            load_ph    <= 1'b0;
            grant_time <= 1'b0;
            prio_time  <= 1'b0;
        end else begin
            load_ph <= start;
            if (start) begin
                conv_act   <= 1'b1;
                grant_time <= gsel_time;
                if (pend_score && pend_time) prio_time <= !gsel_time;
            end else if (conv_done) begin
                conv_act <= 1'b0;
            end
        end
    end

    // A strobe in the LOAD cycle wins over the clear, so the requester is reconverted.
    always_ff @(posedge segclk) begin
        if (reset) begin
            pend_score <= 1'b0;
            pend_time  <= 1'b0;
            pval_score <= '0;
            pval_time  <= '0;
        end else begin
            if (bus.score_vld) begin
                pval_score <= bus.score;
                pend_score <= 1'b1;
            end else if (load_ph && !grant_time) begin
                pend_score <= 1'b0;
            end
            if (bus.time_vld) begin
                pval_time <= bus.time_s;
                pend_time <= 1'b1;
            end else if (load_ph && grant_time) begin
                pend_time <= 1'b0;
            end
        end
    end

    assign sel_val = grant_time ? pval_time : pval_score;
    assign bin     = (sel_val > VAL_W'(99)) ? 7'd99 : sel_val[6:0];

    bin2bcd_seq u_bcd (
        .clk   (segclk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_ff @(posedge segclk) begin
        if (reset) begin
            score_tens <= '0;
            score_ones <= '0;
            time_tens  <= '0;
            time_ones  <= '0;
        end else if (conv_done) begin
            if (grant_time) begin
                time_tens <= conv_tens;
                time_ones <= conv_ones;
            end else begin
                score_tens <= conv_tens;
                score_ones <= conv_ones;
            end
        end
    end

    assign bus.busy = pend_score || pend_time || conv_act;

    always_comb begin
        cur_digit = score_ones;
        case (idx)
            2'd0: cur_digit = score_ones;
            2'd1: cur_digit = score_tens;
            2'd2: cur_digit = time_ones;
            2'd3: cur_digit = time_tens;
            default: cur_digit = score_ones;
        endcase
        nxt_an  = scan_an(idx);
        nxt_seg = digit_to_seg(cur_digit);
        nxt_dp  = (idx != 2'd2);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Odd slots carry tens digits; a blanked slot still consumes its dwell.
        if (idx[0] && (cur_digit == 4'd0)) begin
            nxt_an  = AN_OFF;
            nxt_seg = SEG_BLANK;
            nxt_dp  = 1'b1;
        end
`endif
    end

    always_ff @(posedge segclk) begin
        if (reset) begin
            idx   <= '0;
            dwell <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= nxt_seg;
            an_q  <= nxt_an;
            dp_q  <= nxt_dp;
            if (dwell == DW'(REFRESH_DIV - 1)) begin
                dwell <= '0;
                idx   <= scan_idx_t'(idx + 2'd1);
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset/scan order, conversion latency, arbitration, reconvert, reset abort, vector table.
module tb_seg_scan_ctrl;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic segclk = 1'b0;
    logic reset  = 1'b1;
    int   n_vec  = 0;
    int   n_bad  = 0;

    seg_scan_ctrl_if #(.VAL_W(8)) bus ();

    seg_scan_ctrl #(.REFRESH_DIV(4), .VAL_W(8)) dut (
        .segclk (segclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 segclk = ~segclk;

    typedef struct {
        logic [7:0] score;
        logic [7:0] time_s;
        logic       do_score;
        logic       do_time;
        logic [3:0] st, so, tt, to;
    } vec_t;

    function automatic logic [6:0] enc_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        @(posedge segclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_digits(input string name, input logic [3:0] st, input logic [3:0] so,
                                input logic [3:0] tt, input logic [3:0] to);
        check(name, {dut.score_tens, dut.score_ones, dut.time_tens, dut.time_ones}, {st, so, tt, to});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, bus.busy, 1'b0);
    endtask

    // One full scan period: every lit slot must show its digit, and the slot counts must match.
    task automatic check_display(input logic [3:0] st, input logic [3:0] so,
                                 input logic [3:0] tt, input logic [3:0] to);
        int c0, c1, c2, c3, cb;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; cb = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            case (bus.an)
                4'b1110: begin c0++; check("disp_idx0", {bus.seg, bus.dp}, {enc_of(so), 1'b1}); end
                4'b1101: begin c1++; check("disp_idx1", {bus.seg, bus.dp}, {enc_of(st), 1'b1}); end
                4'b1011: begin c2++; check("disp_idx2", {bus.seg, bus.dp}, {enc_of(to), 1'b0}); end
                4'b0111: begin c3++; check("disp_idx3", {bus.seg, bus.dp}, {enc_of(tt), 1'b1}); end
                default: begin cb++; check("disp_off", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1}); end
            endcase
        end
        check("cnt_idx0", c0, 4);
        check("cnt_idx1", c1, (BLANK && st == 4'd0) ? 0 : 4);
        check("cnt_idx2", c2, 4);
        check("cnt_idx3", c3, (BLANK && tt == 4'd0) ? 0 : 4);
        check("cnt_off", cb, ((BLANK && st == 4'd0) ? 4 : 0) + ((BLANK && tt == 4'd0) ? 4 : 0));
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0] exp_an;
        int slot;

        vecs[0] = '{8'd150, 8'd99,  1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[1] = '{8'd5,   8'd0,   1'b1, 1'b0, 4'd0, 4'd5, 4'd9, 4'd9};
        vecs[2] = '{8'd0,   8'd0,   1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 4'd0};
        vecs[3] = '{8'd99,  8'd100, 1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[4] = '{8'd255, 8'd10,  1'b1, 1'b1, 4'd9, 4'd9, 4'd1, 4'd0};
        vecs[5] = '{8'd60,  8'd0,   1'b1, 1'b0, 4'd6, 4'd0, 4'd1, 4'd0};
        vecs[6] = '{8'd9,   8'd7,   1'b1, 1'b1, 4'd0, 4'd9, 4'd0, 4'd7};

        bus.score = '0; bus.score_vld = 1'b0;
        bus.time_s = '0; bus.time_vld = 1'b0;

        // Reset state and scan order from the first edge after release.
        reset = 1'b1;
        step();
        step();
        check("rst_outputs", {bus.seg, bus.an, bus.dp, bus.busy}, {7'h7F, 4'hF, 1'b1, 1'b0});
        check_digits("rst_digits", 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            slot = ((k - 1) / 4) % 4;
            exp_an = ~(4'b0001 << slot);
            if (BLANK && (slot % 2 == 1)) exp_an = 4'b1111;
            check("scan_order_an", bus.an, exp_an);
            if (k == 1) check("first_seg", {bus.seg, bus.dp}, {7'b1000000, 1'b1});
        end

        // Single request: digits land on the 11th edge after the strobe edge.
        bus.score = 8'd42; bus.score_vld = 1'b1;
        step();
        bus.score_vld = 1'b0;
        check("lat_busy_e0", bus.busy, 1'b1);
        for (int e = 1; e <= 10; e++) begin
            step();
            check("lat_busy", bus.busy, 1'b1);
            check_digits("lat_not_yet", 4'd0, 4'd0, 4'd0, 4'd0);
        end
        step();
        check("lat_busy_e11", bus.busy, 1'b0);
        check_digits("lat_e11", 4'd4, 4'd2, 4'd0, 4'd0);
        check_display(4'd4, 4'd2, 4'd0, 4'd0);

        // Simultaneous requests: score first (reset priority), time 11 edges later.
        bus.score = 8'd7; bus.score_vld = 1'b1;
        bus.time_s = 8'd35; bus.time_vld = 1'b1;
        step();
        bus.score_vld = 1'b0; bus.time_vld = 1'b0;
        check("both_busy_e0", bus.busy, 1'b1);
        for (int e = 1; e <= 22; e++) begin
            step();
            check("both_busy", bus.busy, (e < 22) ? 1'b1 : 1'b0);
            if (e == 10) check_digits("both_e10", 4'd4, 4'd2, 4'd0, 4'd0);
            if (e == 11) check_digits("both_e11", 4'd0, 4'd7, 4'd0, 4'd0);
            if (e == 21) check_digits("both_e21", 4'd0, 4'd7, 4'd0, 4'd0);
            if (e == 22) check_digits("both_e22", 4'd0, 4'd7, 4'd3, 4'd5);
        end
        check_display(4'd0, 4'd7, 4'd3, 4'd5);

        // Strobe during own conversion: first value lands at edge 11, the new one at edge 22.
        bus.score = 8'd12; bus.score_vld = 1'b1;
        step();
        bus.score_vld = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        bus.score = 8'd34; bus.score_vld = 1'b1;
        step();
        bus.score_vld = 1'b0;
        for (int e = 6; e <= 22; e++) begin
            step();
            check("reconv_busy", bus.busy, (e < 22) ? 1'b1 : 1'b0);
            if (e == 11) check_digits("reconv_e11", 4'd1, 4'd2, 4'd3, 4'd5);
            if (e == 21) check_digits("reconv_e21", 4'd1, 4'd2, 4'd3, 4'd5);
            if (e == 22) check_digits("reconv_e22", 4'd3, 4'd4, 4'd3, 4'd5);
        end

        for (int v = 0; v < 7; v++) begin
            bus.score = vecs[v].score; bus.score_vld = vecs[v].do_score;
            bus.time_s = vecs[v].time_s; bus.time_vld = vecs[v].do_time;
            step();
            bus.score_vld = 1'b0; bus.time_vld = 1'b0;
            wait_idle("vec_idle");
            check_digits("vec_digits", vecs[v].st, vecs[v].so, vecs[v].tt, vecs[v].to);
            check_display(vecs[v].st, vecs[v].so, vecs[v].tt, vecs[v].to);
        end

        // Reset at edge 5 of a conversion aborts it and clears everything.
        bus.score = 8'd42; bus.score_vld = 1'b1;
        step();
        bus.score_vld = 1'b0;
        wait_idle("abort_pre_idle");
        check_digits("abort_pre", 4'd4, 4'd2, 4'd0, 4'd7);
        bus.score = 8'd88; bus.score_vld = 1'b1;
        step();
        bus.score_vld = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_outputs", {bus.seg, bus.an, bus.dp, bus.busy}, {7'h7F, 4'hF, 1'b1, 1'b0});
        check_digits("abort_digits", 4'd0, 4'd0, 4'd0, 4'd0);
        for (int e = 0; e < 20; e++) begin
            step();
            check("abort_busy", bus.busy, 1'b0);
            check_digits("abort_no_late", 4'd0, 4'd0, 4'd0, 4'd0);
        end
        check_display(4'd0, 4'd0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
